pipe_stage_hs: RTL and testbench

//  Parametrised pipeline stage register for the RISC-V core (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_hs_if.sv | 15 +
 rtl/pipe_stage_hs.sv | 130 +++++++++++++
 tb/tb_pipe_stage_hs.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_hs_if.sv
// Handshake channel for one side of a pipeline stage: {ctrl,data} payload
// with valid/ready flow control. The master drives the payload, the slave
// drives ready.
interface pipe_stage_hs_if #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8
);
    logic              valid;
    logic              ready;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] data;

    modport master (output valid, output ctrl, output data, input ready);
    modport slave  (input valid, input ctrl, input data, output ready);
endinterface

// File: rtl/pipe_stage_hs.sv
// Pipeline stage register with valid/ready handshake, synchronous flush,
// optional 2-entry skid buffer and a saturating backpressure stall counter.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_EMPTY | nothing held, out_valid=0, main ctrl cleared
//   S_ONE   | main entry valid and presented downstream
//   S_TWO   | main and skid entries valid, upstream blocked (SKID=1 only)
module pipe_stage_hs #(
    parameter int DATA_W = 64,
    parameter int CTRL_W = 8,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    pipe_stage_hs_if.slave   up,
    pipe_stage_hs_if.master  dn,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t            state;
    logic              out_valid_q;
    logic              in_ready_q;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    // Without the skid buffer the stage can refill in the same cycle it
    // drains, so ready has to look at the downstream ready directly.
    assign up.ready = (SKID != 0) ? in_ready_q : (!out_valid_q || dn.ready);

    assign dn.valid = out_valid_q;
    assign dn.ctrl  = main_ctrl;
    assign dn.data  = main_data;

    assign in_fire  = up.valid && up.ready;
    assign out_fire = out_valid_q && dn.ready;

    // Stage FSM: entry movement, registered handshake outputs and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_ctrl   <= '0;
            main_data   <= '0;
            skid_ctrl   <= '0;
            skid_data   <= '0;
            occupancy   <= 2'd0;
        end else if (flush) begin
            // Data bits are left as they are; only ctrl must be scrubbed so
            // the bubble carries no side effects.
            state       <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            main_ctrl   <= '0;
            skid_ctrl   <= '0;
            occupancy   <= 2'd0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (in_fire) begin
                        main_ctrl   <= up.ctrl;
                        main_data   <= up.data;
                        out_valid_q <= 1'b1;
                        occupancy   <= 2'd1;
                        state       <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (in_fire && out_fire) begin
                        main_ctrl <= up.ctrl;
                        main_data <= up.data;
                    end else if (in_fire && (SKID != 0)) begin
                        skid_ctrl  <= up.ctrl;
                        skid_data  <= up.data;
                        in_ready_q <= 1'b0;
                        occupancy  <= 2'd2;
                        state      <= S_TWO;
                    end else if (out_fire) begin
                        main_ctrl   <= '0;
                        out_valid_q <= 1'b0;
                        occupancy   <= 2'd0;
                        state       <= S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (out_fire) begin
                        main_ctrl  <= skid_ctrl;
                        main_data  <= skid_data;
                        skid_ctrl  <= '0;
                        in_ready_q <= 1'b1;
                        occupancy  <= 2'd1;
                        state      <= S_ONE;
                    end
                end
                default: begin
                    state       <= S_EMPTY;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    main_ctrl   <= '0;
                    skid_ctrl   <= '0;
                    occupancy   <= 2'd0;
                end
            endcase
        end
    end

    // Backpressure counter: saturates rather than wraps, untouched by flush.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid_q && !dn.ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: instance a (SKID=1, 4-bit stall counter) and
// instance b (SKID=0). Accepted payloads are queued; monitors pop and
// compare whenever a DUT delivers.
module tb_pipe_stage_hs;

    logic clk;
    logic reset;
    logic flush_a;
    logic flush_b;

    logic [1:0]  occ_a;
    logic [3:0]  stall_a;
    logic [1:0]  occ_b;
    logic [15:0] stall_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [71:0] qa[$];
    logic [71:0] qb[$];

    pipe_stage_hs_if #(.DATA_W(64), .CTRL_W(8)) a_up ();
    pipe_stage_hs_if #(.DATA_W(64), .CTRL_W(8)) a_dn ();
    pipe_stage_hs_if #(.DATA_W(64), .CTRL_W(8)) b_up ();
    pipe_stage_hs_if #(.DATA_W(64), .CTRL_W(8)) b_dn ();

    pipe_stage_hs #(.DATA_W(64), .CTRL_W(8), .SKID(1), .CNT_W(4)) u_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_a),
        .up        (a_up),
        .dn        (a_dn),
        .occupancy (occ_a),
        .stall_cnt (stall_a)
    );

    pipe_stage_hs #(.DATA_W(64), .CTRL_W(8), .SKID(0), .CNT_W(16)) u_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush_b),
        .up        (b_up),
        .dn        (b_dn),
        .occupancy (occ_b),
        .stall_cnt (stall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Monitors: compare every delivered payload against the queue head, and
    // make sure an idle output never shows live control bits.
    always @(negedge clk) begin
        if (!reset) begin
            if (a_dn.valid && a_dn.ready) begin
                if (qa.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected_out: got payload %0h, required none", {a_dn.ctrl, a_dn.data});
                end else begin
                    chk("a_out_payload", {a_dn.ctrl, a_dn.data}, qa.pop_front());
                end
            end
            if (!a_dn.valid) chk("a_idle_ctrl", 72'(a_dn.ctrl), 72'h0);
            if (b_dn.valid && b_dn.ready) begin
                if (qb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected_out: got payload %0h, required none", {b_dn.ctrl, b_dn.data});
                end else begin
                    chk("b_out_payload", {b_dn.ctrl, b_dn.data}, qb.pop_front());
                end
            end
            if (!b_dn.valid) chk("b_idle_ctrl", 72'(b_dn.ctrl), 72'h0);
        end
    end

    // One cycle of stimulus on a; called and returns at posedge+1.
    task automatic step_a(input logic v, input logic [7:0] c, input logic [63:0] d,
                          input logic ordy, input logic fl, output logic fired);
        a_up.valid = v;
        a_up.ctrl  = c;
        a_up.data  = d;
        a_dn.ready = ordy;
        flush_a    = fl;
        @(negedge clk);
        fired = v && a_up.ready;
        if (fired && !fl) qa.push_back({c, d});
        @(posedge clk);
        if (fl) qa.delete();
        #1;
        flush_a = 1'b0;
    endtask

    // One cycle on b, checking the combinational ready right after driving.
    task automatic step_b(input logic v, input logic [7:0] c, input logic [63:0] d,
                          input logic ordy, input logic exp_rdy);
        b_up.valid = v;
        b_up.ctrl  = c;
        b_up.data  = d;
        b_dn.ready = ordy;
        #1;
        chk("b_in_ready_comb", 72'(b_up.ready), 72'(exp_rdy));
        @(negedge clk);
        if (v && b_up.ready) qb.push_back({c, d});
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        qa.delete();
        qb.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at limit 200000");
        $fatal(1);
    end

    initial begin
        logic f;
        reset      = 1'b1;
        flush_a    = 1'b0;
        flush_b    = 1'b0;
        a_up.valid = 1'b1;
        a_up.ctrl  = 8'hFF;
        a_up.data  = '1;
        a_dn.ready = 1'b0;
        b_up.valid = 1'b1;
        b_up.ctrl  = 8'hFF;
        b_up.data  = '1;
        b_dn.ready = 1'b0;

        // Reset held with live input
        repeat (2) @(posedge clk);
        #1;
        chk("rst_a_out_valid", 72'(a_dn.valid), 72'h0);
        chk("rst_a_out_ctrl",  72'(a_dn.ctrl),  72'h0);
        chk("rst_a_out_data",  72'(a_dn.data),  72'h0);
        chk("rst_a_occ",       72'(occ_a),      72'h0);
        chk("rst_a_stall",     72'(stall_a),    72'h0);
        chk("rst_a_in_ready",  72'(a_up.ready), 72'h1);
        chk("rst_b_out_valid", 72'(b_dn.valid), 72'h0);
        chk("rst_b_in_ready",  72'(b_up.ready), 72'h1);
        chk("rst_b_occ",       72'(occ_b),      72'h0);
        a_up.valid = 1'b0;
        b_up.valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Async reset mid-transfer
        step_a(1'b1, 8'hC3, 64'h1234, 1'b0, 1'b0, f);
        step_a(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, f);
        chk("pre_rst_a_stall", 72'(stall_a),    72'h1);
        chk("pre_rst_a_valid", 72'(a_dn.valid), 72'h1);
        a_up.valid = 1'b1;
        a_up.ctrl  = 8'hFF;
        #2;
        reset = 1'b1;
        qa.delete();
        qb.delete();
        #1;
        chk("async_rst_a_valid", 72'(a_dn.valid), 72'h0);
        chk("async_rst_a_ctrl",  72'(a_dn.ctrl),  72'h0);
        chk("async_rst_a_occ",   72'(occ_a),      72'h0);
        chk("async_rst_a_stall", 72'(stall_a),    72'h0);
        @(negedge clk);
        a_up.valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Streaming, no backpressure
        for (int i = 0; i < 10; i++) begin
            step_a(1'b1, 8'(i + 1), 64'(i), 1'b1, 1'b0, f);
            chk("a_stream_fire", 72'(f),          72'h1);
            chk("a_stream_rdy",  72'(a_up.ready), 72'h1);
            chk("a_stream_occ",  72'(occ_a),      72'h1);
        end
        step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, f);
        chk("a_stream_drained", 72'(qa.size()), 72'h0);
        chk("a_stream_occ_end", 72'(occ_a),     72'h0);
        chk("a_stream_stall",   72'(stall_a),   72'h0);

        // Backpressure into the skid entry
        step_a(1'b1, 8'hA1, 64'hAAAA, 1'b0, 1'b0, f);
        chk("bp_a_occ",   72'(occ_a),      72'h1);
        chk("bp_a_rdy",   72'(a_up.ready), 72'h1);
        step_a(1'b1, 8'hB2, 64'hBBBB, 1'b0, 1'b0, f);
        chk("bp_b_fire",  72'(f),          72'h1);
        chk("bp_b_occ",   72'(occ_a),      72'h2);
        chk("bp_b_rdy",   72'(a_up.ready), 72'h0);
        chk("bp_b_stall", 72'(stall_a),    72'h1);
        step_a(1'b1, 8'hC4, 64'hCCCC, 1'b0, 1'b0, f);
        chk("bp_c_held",  72'(f),          72'h0);
        chk("bp_c_occ",   72'(occ_a),      72'h2);
        chk("bp_c_stall", 72'(stall_a),    72'h2);
        step_a(1'b1, 8'hC4, 64'hCCCC, 1'b1, 1'b0, f);
        chk("bp_drain1_fire", 72'(f),          72'h0);
        chk("bp_drain1_occ",  72'(occ_a),      72'h1);
        chk("bp_drain1_rdy",  72'(a_up.ready), 72'h1);
        step_a(1'b1, 8'hC4, 64'hCCCC, 1'b1, 1'b0, f);
        chk("bp_drain2_fire", 72'(f),          72'h1);
        chk("bp_drain2_occ",  72'(occ_a),      72'h1);
        step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, f);
        chk("bp_end_occ",   72'(occ_a),     72'h0);
        chk("bp_end_stall", 72'(stall_a),   72'h2);
        chk("bp_end_queue", 72'(qa.size()), 72'h0);

        // Flush while holding two entries, with an incoming payload
        step_a(1'b1, 8'h11, 64'hD, 1'b0, 1'b0, f);
        step_a(1'b1, 8'h22, 64'hE, 1'b0, 1'b0, f);
        chk("fl_pre_occ", 72'(occ_a), 72'h2);
        step_a(1'b1, 8'h5A, 64'hF, 1'b0, 1'b1, f);
        chk("fl_valid", 72'(a_dn.valid), 72'h0);
        chk("fl_ctrl",  72'(a_dn.ctrl),  72'h0);
        chk("fl_occ",   72'(occ_a),      72'h0);
        chk("fl_rdy",   72'(a_up.ready), 72'h1);
        chk("fl_stall", 72'(stall_a),    72'h4);
        step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, f);
        step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, f);
        chk("fl_post_valid", 72'(a_dn.valid), 72'h0);

        // Delivery in the flush cycle still counts; incoming is dropped
        step_a(1'b1, 8'h33, 64'h6, 1'b1, 1'b0, f);
        step_a(1'b1, 8'h44, 64'h7, 1'b1, 1'b1, f);
        chk("fl_of_occ",   72'(occ_a),      72'h0);
        chk("fl_of_valid", 72'(a_dn.valid), 72'h0);
        chk("fl_of_queue", 72'(qa.size()),  72'h0);
        step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, f);

        // SKID=0: combinational ready, single entry
        step_b(1'b1, 8'h21, 64'hAA, 1'b1, 1'b1);
        chk("b_p_occ", 72'(occ_b), 72'h1);
        step_b(1'b1, 8'h42, 64'hBB, 1'b0, 1'b0);
        chk("b_q_refused_occ", 72'(occ_b), 72'h1);
        step_b(1'b1, 8'h42, 64'hBB, 1'b1, 1'b1);
        chk("b_q_accept_occ", 72'(occ_b), 72'h1);
        step_b(1'b0, 8'h00, 64'h0, 1'b1, 1'b1);
        chk("b_end_occ",   72'(occ_b),      72'h0);
        chk("b_end_valid", 72'(b_dn.valid), 72'h0);
        chk("b_stall",     72'(stall_b),    72'h1);
        step_b(1'b0, 8'h00, 64'h0, 1'b0, 1'b1);
        chk("b_end_queue", 72'(qb.size()), 72'h0);

        // Stall counter saturation
        do_reset();
        step_a(1'b1, 8'h77, 64'h5A5A, 1'b0, 1'b0, f);
        chk("sat_start", 72'(stall_a), 72'h0);
        for (int i = 1; i <= 20; i++) begin
            step_a(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, f);
            chk("sat_count", 72'(stall_a), 72'((i > 15) ? 15 : i));
        end
        step_a(1'b0, 8'h00, 64'h0, 1'b1, 1'b0, f);
        chk("sat_hold",  72'(stall_a),   72'hF);
        chk("sat_queue", 72'(qa.size()), 72'h0);
        step_a(1'b0, 8'h00, 64'h0, 1'b0, 1'b0, f);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
